demux1to2_stream: RTL and testbench
===================================

Name: demux1to2_stream

Overview:
- 1-to-2 stream demultiplexer: the inverse of the team's 2:1 byte mux.
- Routes each accepted input word to output 0 or output 1 according to in_sel.
- Uses valid/ready handshakes with a one-entry register slot per output.
- Keeps per-output transfer counters for the functional-coverage benches.
- Sits between a single producer and two independent consumers.

Parameters:
WIDTH, 8, data width of input and both outputs
CNT_W, 16, width of each per-output transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  block can accept the word at the current in_sel
in_data  input  WIDTH  input word
in_sel  input  1  destination: 0 -> out0, 1 -> out1; qualified by in_valid
out0_valid  output  1  slot 0 holds a word
out0_ready  input  1  consumer 0 accepts
out0_data  output  WIDTH  slot 0 word
out1_valid  output  1  slot 1 holds a word
out1_ready  input  1  consumer 1 accepts
out1_data  output  WIDTH  slot 1 word
clear_cnt  input  1  synchronous clear of both counters
cnt0  output  CNT_W  completed transfers on out0
cnt1  output  CNT_W  completed transfers on out1

Behaviour:
- Reset: rst_n low asynchronously forces outN_valid=0, outN_data=0, cnt0=cnt1=0. Any buffered words are discarded. Operation resumes on the first clk edge after rst_n rises.
- Slot state per output: EMPTY or FULL. outN_valid=1 exactly when slot N is FULL.
- in_ready is combinational: in_ready = (slot[in_sel]==EMPTY) | outN_ready, where N=in_sel. The state of the non-selected slot has no effect, so there is no head-of-line blocking.
- Accept: in_valid & in_ready at an edge loads in_data into slot[in_sel]. Latency is exactly 1 cycle: the word appears on outN_data with outN_valid=1 the cycle after acceptance.
- Drain: outN_valid & outN_ready at an edge empties slot N, unless the same edge loads it.
- Simultaneous drain and load of the same slot: slot stays FULL, data is replaced by the new word, outN_valid does not drop. This gives full throughput of 1 word per cycle per output.
- Both slots can drain in the same cycle. Only one slot can load per cycle.
- Stall: while outN_valid=1 and outN_ready=0, outN_data is held stable.
- Protocol rules for the producer: once in_valid=1, in_data and in_sel must stay stable until accepted. Asserting in_ready has no dependency on in_valid.
- Counters:
  - cntN increments by 1 on each out handshake (outN_valid & outN_ready).
  - Counters wrap modulo 2^CNT_W, so 0xFFFF+1 gives 0x0000 when CNT_W=16.
  - clear_cnt=1 sets both counters to 0 at the next edge. Clear takes priority over a simultaneous increment: result is 0, not 1.
- There is no other state. The block introduces no combinational path from in_* to out_*.

Decomposition:
- Package demux_pkg holds:
  - enum slot_state_t {SLOT_EMPTY, SLOT_FULL}
  - localparam DEFAULT_WIDTH=8
  - localparam DEFAULT_CNT_W=16
- Sub-module out_slot: a one-entry register slice with load/drain, valid, data and counter. It is instantiated twice. The top level holds only the in_ready select and the load-enable decode.

Test Plan:
1. Reset with in_valid=1 and in_sel=0 held: outputs stay 0 during reset. Release, then send 0xA5 to sel=0 with out0_ready=1 -> out0_valid=1 and out0_data=0xA5 one cycle later; cnt0=1 after that edge; cnt1=0.
2. Back-pressure: out1_ready=0, send 0x11 to sel=1 -> slot 1 FULL. Next word 0x22 to sel=1 sees in_ready=0. Switch in_sel=0 with 0x33 -> in_ready=1, out0_data=0x33 next cycle, and out1_data stays 0x11.
3. Streaming: out0_ready=1 with 8 back-to-back words 0x00..0x07 on sel=0 -> in_ready stays 1 throughout. out0 shows 0x00..0x07 on consecutive cycles, out0_valid is never deasserted, cnt0=8.
4. Counter boundaries:
   - Preload by issuing 65535 transfers on out1; one more transfer wraps cnt1 to 0x0000.
   - Assert clear_cnt in the same cycle as an out0 handshake -> cnt0=0.
5. Mid-operation reset: with both slots FULL (0x5A on out0, 0xC3 on out1) and both readies low, pulse rst_n low between edges -> valids drop immediately and counters read 0. No stale word appears after reset release.
6. Random constrained traffic (in_sel and readies each 50% toggled) over 10k cycles vs. a scoreboard -> per-output order preserved, no loss or duplication, and cnt0+cnt1 equals the number of accepted words minus the words still buffered.

Source files
------------

// File: rtl/demux1to2_stream_pkg.sv
// Shared types and default sizes for the 1-to-2 stream demultiplexer.
// Imported by the output slot and the top level.
package demux_pkg;

   // A slot is either holding a word for its consumer or free to take one.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/demux1to2_stream_out_slot.sv
// One-entry register slice feeding a single consumer, with its own
// completed-transfer counter. The top level instantiates one per output.
module out_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   input  logic             clear_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             loadable_o
);

   slot_state_t      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drain;

   assign drain = (state_q == SLOT_FULL) && ready_i;

   // A load on the same edge as a drain keeps the slot full, which is what
   // lets a consumer take one word per cycle without a bubble.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         state_d = SLOT_FULL;
         data_d  = data_i;
      end else if (drain) begin
         state_d = SLOT_EMPTY;
      end
      if (clear_i) begin
         cnt_d = '0;
      end else if (drain) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_o    = (state_q == SLOT_FULL);
   assign data_o     = data_q;
   assign cnt_o      = cnt_q;
   assign loadable_o = (state_q == SLOT_EMPTY) || ready_i;

endmodule

// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demultiplexer: steers each accepted word to the slot chosen
// by in_sel. Only the selected slot gates in_ready, so no head-of-line blocking.
module demux1to2_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   input  logic             clear_cnt,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic loadable0, loadable1;
   logic accept, load0, load1;

   assign in_ready = in_sel ? loadable1 : loadable0;
   assign accept   = in_valid && in_ready;
   assign load0    = accept && !in_sel;
   assign load1    = accept &&  in_sel;

   out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load0),
      .data_i    (in_data),
      .ready_i   (out0_ready),
      .clear_i   (clear_cnt),
      .valid_o   (out0_valid),
      .data_o    (out0_data),
      .cnt_o     (cnt0),
      .loadable_o(loadable0)
   );

   out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load1),
      .data_i    (in_data),
      .ready_i   (out1_ready),
      .clear_i   (clear_cnt),
      .valid_o   (out1_valid),
      .data_o    (out1_data),
      .cnt_o     (cnt1),
      .loadable_o(loadable1)
   );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Self-checking bench for demux1to2_stream: directed scenarios followed by
// random traffic, all compared against a slot-level reference model.
module tb_demux1to2_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_sel;
   logic        out0_valid;
   logic        out0_ready;
   logic [7:0]  out0_data;
   logic        out1_valid;
   logic        out1_ready;
   logic [7:0]  out1_data;
   logic        clear_cnt;
   logic [15:0] cnt0;
   logic [15:0] cnt1;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: each output is a one-word buffer plus a wrapping counter.
   bit          mFull [2];
   logic [7:0]  mData [2];
   logic [15:0] mCnt  [2];
   bit          lastAccept;
   int          acceptedRnd;

   demux1to2_stream #(.WIDTH(8), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out0_valid(out0_valid),
      .out0_ready(out0_ready),
      .out0_data (out0_data),
      .out1_valid(out1_valid),
      .out1_ready(out1_ready),
      .out1_data (out1_data),
      .clear_cnt (clear_cnt),
      .cnt0      (cnt0),
      .cnt1      (cnt1)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      for (int n = 0; n < 2; n++) begin
         mFull[n] = 1'b0;
         mData[n] = 8'h00;
         mCnt[n]  = 16'h0000;
      end
   endtask

   // Drive one cycle of inputs, check everything before the edge, then
   // advance the model by the handshake rules at the edge.
   task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d,
                                input logic r0, input logic r1, input logic clr);
      logic expReady;
      bit   drain [2];
      in_valid   = v;
      in_sel     = s;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
      clear_cnt  = clr;
      @(negedge clk);
      expReady = !mFull[s] || (s ? r1 : r0);
      checkOutput("inReady",   32'(in_ready),   32'(expReady));
      checkOutput("out0Valid", 32'(out0_valid), 32'(mFull[0]));
      checkOutput("out0Data",  32'(out0_data),  32'(mData[0]));
      checkOutput("out1Valid", 32'(out1_valid), 32'(mFull[1]));
      checkOutput("out1Data",  32'(out1_data),  32'(mData[1]));
      checkOutput("cnt0",      32'(cnt0),       32'(mCnt[0]));
      checkOutput("cnt1",      32'(cnt1),       32'(mCnt[1]));
      @(posedge clk);
      if (!rst_n) begin
         resetModel();
         lastAccept = 1'b0;
      end else begin
         lastAccept = v && expReady;
         drain[0] = mFull[0] && r0;
         drain[1] = mFull[1] && r1;
         for (int n = 0; n < 2; n++) begin
            if (drain[n]) begin
               mCnt[n]  = mCnt[n] + 16'd1;
               mFull[n] = 1'b0;
            end
            if (clr) mCnt[n] = 16'h0000;
         end
         if (lastAccept) begin
            mFull[s] = 1'b1;
            mData[s] = d;
            acceptedRnd++;
         end
      end
      #1;
   endtask

   initial begin
      logic v, s, r0, r1;
      logic [7:0] d;
      resetModel();
      lastAccept  = 1'b0;
      acceptedRnd = 0;
      rst_n = 1'b0;

      // Reset held while the producer already offers a word to out0.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
      checkOutput("t1Valid", 32'(out0_valid), 32'd1);
      checkOutput("t1Data",  32'(out0_data),  32'hA5);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("t1Cnt0", 32'(cnt0), 32'd1);
      checkOutput("t1Cnt1", 32'(cnt1), 32'd0);

      // Back-pressure on out1 must not block traffic bound for out0.
      applyStimulus(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      checkOutput("t2Blocked", 32'(lastAccept), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
      checkOutput("t2Out0", 32'(out0_data), 32'h33);
      checkOutput("t2Out1", 32'(out1_data), 32'h11);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

      // Back-to-back streaming into out0.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, 1'b0);
         checkOutput("t3Accept", 32'(lastAccept), 32'd1);
         checkOutput("t3Data", 32'(out0_data), 32'(i));
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("t3Cnt0", 32'(cnt0), 32'd8);

      // Wrap cnt1 through 0xFFFF.
      for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
      checkOutput("t4Max", 32'(cnt1), 32'hFFFF);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("t4Wrap", 32'(cnt1), 32'h0000);

      // Clear wins over a simultaneous out0 handshake.
      applyStimulus(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      checkOutput("t4Clear", 32'(cnt0), 32'd0);

      // Asynchronous reset between edges with both slots full and stalled.
      applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
      checkOutput("t5Full0", 32'(out0_valid), 32'd1);
      checkOutput("t5Full1", 32'(out1_valid), 32'd1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkOutput("t5Valid0", 32'(out0_valid), 32'd0);
      checkOutput("t5Valid1", 32'(out1_valid), 32'd0);
      checkOutput("t5Cnt0",   32'(cnt0),       32'd0);
      checkOutput("t5Cnt1",   32'(cnt1),       32'd0);
      #1;
      rst_n = 1'b1;
      resetModel();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

      // Random traffic; the producer holds its word until it is accepted.
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      acceptedRnd = 0;
      lastAccept  = 1'b1;
      v = 1'b0;
      s = 1'b0;
      d = 8'h00;
      for (int i = 0; i < 10000; i++) begin
         if (!v || lastAccept) begin
            v = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            d = 8'($urandom);
         end
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         applyStimulus(v, s, d, r0, r1, 1'b0);
      end
      checkOutput("t6CntSum", 32'(cnt0) + 32'(cnt1),
                  32'(acceptedRnd - int'(mFull[0]) - int'(mFull[1])));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
